hlpte_fwd_tq: RTL

- Forward 4x4 integer transform and quantization stage of the HLPTE pipeline.
- Sits directly downstream of the HLPTE prediction/residual stage and consumes its residual stream.
- Accepts one 4x4 block of signed residuals serially and computes W = C·X·Cᵀ, using the H.264 core matrix C = [1 1 1 1; 2 1 -1 -2; 1 -1 -1 1; 1 -2 2 -1].
- Quantizes each coefficient with the QP supplied for that block and streams out 16 signed levels in raster order.

---
 rtl/hlpte_fwd_tq.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/hlpte_fwd_tq.sv
// Forward 4x4 H.264-style integer transform and quantizer for the HLPTE residual stream.
// Rows are transformed as they arrive; columns in one XFORM cycle; levels leave via a 2-stage quant pipe.
module hlpte_fwd_tq #(
  parameter int unsigned DW = 9,
  parameter int unsigned OW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic [4:0]    qp,
  output logic          busy,
  output logic          out_valid,
  output logic [OW-1:0] out_value
);

  typedef enum logic [1:0] {StIdle, StLoad, StXform, StOut} state_e;

  state_e             state_q;
  logic [3:0]         cnt_q;
  logic [4:0]         qp_q;
  logic signed [15:0] x_q [3];
  logic signed [15:0] t_q [16];
  logic signed [15:0] w_q [16];
  logic               v1_q;
  logic               neg1_q;
  logic [29:0]        sum1_q;

  // One output of the 1-D core transform C applied to the vector (a, b, c, d).
  function automatic logic signed [15:0] coef(input logic [1:0] k, input logic signed [15:0] a,
                                              input logic signed [15:0] b,
                                              input logic signed [15:0] c,
                                              input logic signed [15:0] d);
    unique case (k)
      2'd0:    coef = a + b + c + d;
      2'd1:    coef = (a <<< 1) + b - c - (d <<< 1);
      2'd2:    coef = a - b - c + d;
      default: coef = a - (b <<< 1) + (c <<< 1) - d;
    endcase
  endfunction

  // cls: 0 = both even, 1 = both odd, 2 = mixed.
  function automatic logic [13:0] mf_lookup(input logic [2:0] m, input logic [1:0] cls);
    logic [13:0] a, b, c;
    unique case (m)
      3'd0:    begin a = 14'd13107; b = 14'd5243; c = 14'd8066; end
      3'd1:    begin a = 14'd11916; b = 14'd4660; c = 14'd7490; end
      3'd2:    begin a = 14'd10082; b = 14'd4194; c = 14'd6554; end
      3'd3:    begin a = 14'd9362;  b = 14'd3647; c = 14'd5825; end
      3'd4:    begin a = 14'd8192;  b = 14'd3355; c = 14'd5243; end
      default: begin a = 14'd7282;  b = 14'd2893; c = 14'd4559; end
    endcase
    mf_lookup = (cls == 2'd0) ? a : (cls == 2'd1) ? b : c;
  endfunction

  logic [2:0]         qdiv, qmod;
  logic [4:0]         qbits;
  logic [29:0]        fval;
  logic [1:0]         cls;
  logic [13:0]        mf;
  logic signed [15:0] w_cur, x_in;
  logic [15:0]        w_abs;
  logic [OW-1:0]      lvl;
  logic               cap;
  logic [3:0]         cap_idx;

  always_comb begin
    qdiv  = 3'(qp_q / 5'd6);
    qmod  = 3'(qp_q % 5'd6);
    qbits = 5'd15 + 5'(qdiv);
    unique case (qdiv)
      3'd0:    fval = 30'd10922;
      3'd1:    fval = 30'd21845;
      3'd2:    fval = 30'd43690;
      3'd3:    fval = 30'd87381;
      default: fval = 30'd174762;
    endcase
    if (!cnt_q[2] && !cnt_q[0])    cls = 2'd0;
    else if (cnt_q[2] && cnt_q[0]) cls = 2'd1;
    else                           cls = 2'd2;
    mf      = mf_lookup(qmod, cls);
    w_cur   = w_q[cnt_q];
    w_abs   = w_cur[15] ? 16'(-w_cur) : 16'(w_cur);
    lvl     = OW'(sum1_q >> qbits);
    x_in    = 16'($signed(in_data));
    // A new block is only accepted once the quant pipe has fully drained.
    cap     = in_valid && ((state_q == StLoad) ||
                           (state_q == StIdle && !v1_q && !out_valid));
    cap_idx = (state_q == StIdle) ? 4'd0 : cnt_q;
  end

  assign busy = (state_q != StIdle) || v1_q || out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      qp_q      <= '0;
      v1_q      <= 1'b0;
      neg1_q    <= 1'b0;
      sum1_q    <= '0;
      out_valid <= 1'b0;
      out_value <= '0;
      for (int i = 0; i < 3; i++)  x_q[i] <= '0;
      for (int i = 0; i < 16; i++) begin
        t_q[i] <= '0;
        w_q[i] <= '0;
      end
    end else begin
      out_valid <= v1_q;
      out_value <= !v1_q ? '0 : (neg1_q ? OW'(-lvl) : lvl);
      v1_q      <= 1'b0;

      if (cap) begin
        if (cap_idx[1:0] != 2'd3) begin
          x_q[cap_idx[1:0]] <= x_in;
        end else begin
          for (int k = 0; k < 4; k++)
            t_q[{cap_idx[3:2], 2'(k)}] <= coef(2'(k), x_q[0], x_q[1], x_q[2], x_in);
        end
      end

      unique case (state_q)
        StIdle: if (cap) begin
          qp_q    <= (qp > 5'd29) ? 5'd29 : qp;
          cnt_q   <= 4'd1;
          state_q <= StLoad;
        end
        StLoad: if (cap) begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) state_q <= StXform;
        end
        StXform: begin
          for (int j = 0; j < 4; j++)
            for (int k = 0; k < 4; k++)
              w_q[k*4+j] <= coef(2'(k), t_q[j], t_q[4+j], t_q[8+j], t_q[12+j]);
          cnt_q   <= '0;
          state_q <= StOut;
        end
        default: begin
          v1_q   <= 1'b1;
          sum1_q <= 30'(w_abs) * 30'(mf) + fval;
          neg1_q <= w_cur[15];
          cnt_q  <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
